// File: rtl/sr_pulse_debouncer_pkg.sv
// Shared definitions for the SR pulse debouncer: channel FSM state
// encodings and the default debounce length.
package sr_pulse_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } ch_state_e;

    localparam int DB_CYCLES_DEF = 4;

endpackage

// File: rtl/sr_debounce_ch.sv
// One debounce channel: optional 2-flop synchronizer (SR_SYNC_EN),
// stability counter and press/release FSM; emits a combinational req.
module sr_debounce_ch
    import sr_pulse_debouncer_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic req
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic            in_lvl;
    ch_state_e       state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

`ifdef SR_SYNC_EN
    logic [1:0] sync_d, sync_q;

    always_comb sync_d = {sync_q[0], btn_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end

    assign in_lvl = sync_q[1];
`else
    assign in_lvl = btn_raw;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_lvl) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!in_lvl) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    req     = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!in_lvl) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (in_lvl) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/sr_pulse_debouncer.sv
// Debounced SR pulse generator with S/R arbitration and latch mirror.
// Define SR_SYNC_EN to add input synchronizers in each channel.
module sr_pulse_debouncer
    import sr_pulse_debouncer_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set_raw,
    input  logic btn_rst_raw,
    output logic s,
    output logic r,
    output logic conflict,
    output logic q_mirror
);

    logic req_s, req_r;
    logic s_d, s_q;
    logic r_d, r_q;
    logic conflict_d, conflict_q;
    logic q_mirror_d, q_mirror_q;

    sr_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_set_ch (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_set_raw),
        .req     (req_s)
    );

    sr_debounce_ch #(.DB_CYCLES(DB_CYCLES)) u_rst_ch (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_rst_raw),
        .req     (req_r)
    );

    // Simultaneous requests are dropped so the latch never sees S=R=1.
    always_comb begin
        s_d        = req_s & ~req_r;
        r_d        = req_r & ~req_s;
        conflict_d = req_s & req_r;
        q_mirror_d = q_mirror_q;
        if (s_q)      q_mirror_d = 1'b1;
        else if (r_q) q_mirror_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            conflict_q <= 1'b0;
            q_mirror_q <= 1'b0;
        end else begin
            s_q        <= s_d;
            r_q        <= r_d;
            conflict_q <= conflict_d;
            q_mirror_q <= q_mirror_d;
        end
    end

    assign s        = s_q;
    assign r        = r_q;
    assign conflict = conflict_q;
    assign q_mirror = q_mirror_q;

endmodule

// File: tb/tb_sr_pulse_debouncer.sv
// Self-checking bench for sr_pulse_debouncer (DB_CYCLES=4).
module tb_sr_pulse_debouncer;

`ifdef SR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    typedef struct {
        logic       set;
        logic       rst;
        logic [3:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic btn_set_raw;
    logic btn_rst_raw;
    logic s, r, conflict, q_mirror;

    vec_t       vecs[$];
    logic [3:0] sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    sr_pulse_debouncer #(.DB_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_set_raw (btn_set_raw),
        .btn_rst_raw (btn_rst_raw),
        .s           (s),
        .r           (r),
        .conflict    (conflict),
        .q_mirror    (q_mirror)
    );

    wire [3:0] outs = {s, r, conflict, q_mirror};

    task automatic chk(input string name, input logic [3:0] got,
                       input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: s/r/conflict/q got %b required %b",
                     name, got, exp);
        end
    endtask

    function automatic void add(input logic bs, input logic br,
                                input logic es, input logic er,
                                input logic ec, input logic eq, input int n);
        for (int k = 0; k < n; k++)
            vecs.push_back('{bs, br, {es, er, ec, eq}});
    endfunction

    task automatic step(input logic bs, input logic br);
        btn_set_raw = bs;
        btn_rst_raw = br;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1);
    end

    initial begin
        int popped;

        // set held 4: s on 4th sample, mirror follows, then release
        add(1, 0, 0, 0, 0, 0, 3);
        add(1, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 6);
        // reset held 20: one r pulse only
        add(0, 1, 0, 0, 0, 1, 3);
        add(0, 1, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 0, 0, 16);
        // minimal 4-cycle release then a second press
        add(0, 0, 0, 0, 0, 0, 4);
        add(0, 1, 0, 0, 0, 0, 3);
        add(0, 1, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 6);
        // bouncy set: 1,1,1,0,1,1,1,1
        add(1, 0, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 3);
        add(1, 0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1, 6);
        // both buttons together: conflict, mirror unchanged
        add(1, 1, 0, 0, 0, 1, 3);
        add(1, 1, 0, 0, 1, 1, 1);
        add(0, 0, 0, 0, 0, 1, 6);

        // reset with random buttons, including the asserting cycle
        btn_set_raw = 1'b0;
        btn_rst_raw = 1'b0;
        rst = 1'b1;
        #1;
        chk("reset_initial", outs, 4'b0000);
        for (int i = 0; i < 8; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk($sformatf("reset_rand%0d", i), outs, 4'b0000);
        end
        btn_set_raw = 1'b0;
        btn_rst_raw = 1'b0;
        rst = 1'b0;
        step(0, 0);

        popped = 0;
        for (int i = 0; i < vecs.size() + LAT; i++) begin
            if (i < vecs.size()) begin
                btn_set_raw = vecs[i].set;
                btn_rst_raw = vecs[i].rst;
                sb.push_back(vecs[i].exp);
            end else begin
                btn_set_raw = 1'b0;
                btn_rst_raw = 1'b0;
            end
            @(posedge clk);
            #1;
            if (sb.size() > LAT) begin
                chk($sformatf("vec%0d", popped), outs, sb.pop_front());
                popped++;
            end
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, required 0",
                     sb.size());
        end

        // reset asserted while an s pulse is on the output
        for (int i = 0; i < 4 + LAT; i++) step(1, 0);
        chk("pulse_before_rst", outs, 4'b1001);
        rst = 1'b1;
        #1;
        chk("rst_async", outs, 4'b0000);
        for (int i = 0; i < 10; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            chk($sformatf("rst_hold%0d", i), outs, 4'b0000);
        end
        btn_set_raw = 1'b0;
        btn_rst_raw = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) step(0, 0);

        // reset after 2 high samples discards the press in progress
        step(1, 0);
        step(1, 0);
        rst = 1'b1;
        #1;
        chk("mid_press_rst", outs, 4'b0000);
        step(1, 0);
        rst = 1'b0;
        step(1, 0);
        step(1, 0);
        for (int i = 0; i < 6 + LAT; i++) begin
            step(0, 0);
            chk($sformatf("no_pulse%0d", i), outs, 4'b0000);
        end

        // a full press afterwards still works, latency 4+LAT
        for (int i = 0; i < 3 + LAT; i++) begin
            step(1, 0);
            chk($sformatf("lat_wait%0d", i), outs, 4'b0000);
        end
        step(1, 0);
        chk("lat_pulse", outs, 4'b1000);
        step(0, 0);
        chk("lat_mirror", outs, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
